// File: rtl/cube_game_pkg.sv
// cube_game_pkg: shared types and constants for the falling-cube game.
//   state_t    sequencer states (idle, running, game over)
//   CUBE_SIZE, SCREEN_W, SCREEN_H  playfield geometry in pixels
//   LFSR_SEED  reload value of the spawn LFSR
//   PALETTE    eight 8-bit RRRGGGBB spawn colours
//   lfsr_step  one Fibonacci step (taps 16,14,13,11) with zero recovery
package cube_game_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAME_OVER} state_t;
    localparam int CUBE_SIZE = 60;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [7:0] PALETTE [8] = '{8'hE0, 8'hFC, 8'h1C, 8'h1F, 8'h03, 8'hE3, 8'hFF, 8'h92};
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v == 16'h0) ? LFSR_SEED : {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction
endpackage

// File: rtl/cube_rr_picker.sv
// cube_rr_picker: combinational round-robin search for the first free slot.
//   busy   per-slot busy flags
//   ptr    slot where the search starts
//   found  high when any slot is free
//   idx    first free slot at or after ptr, wrapping
module cube_rr_picker #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  busy,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] idx
);
    logic [PW-1:0] j;
    // Scan from the far end back towards ptr so the last hit is the nearest one.
    always_comb begin
        found = 1'b0;
        idx = '0;
        j = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = PW'((int'(ptr) + i) % N);
            if (!busy[j]) begin
                found = 1'b1;
                idx = j;
            end
        end
    end
endmodule

// File: rtl/cube_spawn_scheduler.sv
// cube_spawn_scheduler: game sequencer that spawns cubes into free slots and keeps score.
//   clk, reset               clock, async active-high reset
//   start_game               pulse: start or restart a game
//   frame_tick               one pulse per video frame
//   cube_caught, cube_missed per-slot landing pulses from the cubes
//   cube_start               one-hot spawn pulse, with cube_x/cube_vel/cube_color
//   score, misses, level     game counters
//   game_active, game_over   state flags
module cube_spawn_scheduler
    import cube_game_pkg::*;
#(
    parameter int N_CUBES = 4,
    parameter int SPAWN_INIT = 60,
    parameter int SPAWN_MIN = 12,
    parameter int SPAWN_STEP = 8,
    parameter int LEVEL_PTS = 10,
    parameter int MAX_MISSES = 5,
    parameter int X_MAX = 440,
    parameter int SCORE_W = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_game,
    input  logic               frame_tick,
    input  logic [N_CUBES-1:0] cube_caught,
    input  logic [N_CUBES-1:0] cube_missed,
    output logic [N_CUBES-1:0] cube_start,
    output logic [8:0]         cube_x,
    output logic [1:0]         cube_vel,
    output logic [7:0]         cube_color,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         misses,
    output logic [3:0]         level,
    output logic               game_active,
    output logic               game_over
);
    localparam int PW = (N_CUBES > 1) ? $clog2(N_CUBES) : 1;
    localparam int CW = $clog2(SPAWN_INIT + 1);
    localparam int NW = $clog2(N_CUBES + 1);
    localparam int KW = $clog2(LEVEL_PTS + N_CUBES + 1);

    state_t state;
    logic [15:0] lfsr;
    logic [N_CUBES-1:0] busy, pick_hot;
    logic [PW-1:0] rr_ptr, pick_idx;
    logic pick_found, spawn;
    logic [CW-1:0] frame_cnt, interval, interval_dn;
    logic [KW-1:0] catch_cnt, catch_sum;
    logic [NW-1:0] n_catch, n_miss;
    logic [SCORE_W:0] score_sum;
    logic [4:0] miss_sum;
    logic [8:0] raw;

    cube_rr_picker #(.N(N_CUBES)) picker (
        .busy(busy),
        .ptr(rr_ptr),
        .found(pick_found),
        .idx(pick_idx)
    );

    // Only cubes we launched may score or miss; stray pulses are masked by busy.
    assign n_catch = NW'($countones(cube_caught & busy));
    assign n_miss = NW'($countones(cube_missed & busy));
    assign catch_sum = catch_cnt + KW'(n_catch);
    assign score_sum = {1'b0, score} + (SCORE_W + 1)'(n_catch);
    assign miss_sum = {1'b0, misses} + 5'(n_miss);
    assign interval_dn = (int'(interval) >= SPAWN_MIN + SPAWN_STEP) ? interval - CW'(SPAWN_STEP) : CW'(SPAWN_MIN);
    assign pick_hot = N_CUBES'(1) << pick_idx;
    assign spawn = (state == S_RUN) && !start_game && (frame_cnt >= interval) && pick_found;
    // Fold the top half of the 9-bit range back on-screen instead of clamping.
    assign raw = lfsr[8:0];
    assign game_active = (state == S_RUN);
    assign game_over = (state == S_GAME_OVER);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            lfsr <= LFSR_SEED;
            busy <= '0;
            rr_ptr <= '0;
            frame_cnt <= '0;
            interval <= CW'(SPAWN_INIT);
            catch_cnt <= '0;
            cube_start <= '0;
            cube_x <= '0;
            cube_vel <= '0;
            cube_color <= '0;
            score <= '0;
            misses <= '0;
            level <= '0;
        end else begin
            lfsr <= lfsr_step(lfsr);
            cube_start <= '0;
            if (start_game) begin
                state <= S_RUN;
                busy <= '0;
                frame_cnt <= '0;
                interval <= CW'(SPAWN_INIT);
                catch_cnt <= '0;
                score <= '0;
                misses <= '0;
                level <= '0;
            end else begin
                busy <= (busy & ~(cube_caught | cube_missed)) | (spawn ? pick_hot : '0);
                if (state == S_RUN) begin
                    if (spawn) begin
                        cube_start <= pick_hot;
                        frame_cnt <= '0;
                        rr_ptr <= PW'((int'(pick_idx) + 1) % N_CUBES);
                        cube_x <= (raw > 9'(X_MAX)) ? raw - 9'd256 : raw;
                        cube_vel <= (lfsr[10:9] == 2'd0) ? 2'd1 : lfsr[10:9];
                        cube_color <= PALETTE[lfsr[13:11]];
                    end else if (frame_tick && frame_cnt < interval) begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                    score <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                    misses <= miss_sum[4] ? 4'hF : miss_sum[3:0];
                    if (catch_sum >= KW'(LEVEL_PTS)) begin
                        catch_cnt <= catch_sum - KW'(LEVEL_PTS);
                        level <= (level == 4'hF) ? level : level + 4'd1;
                        interval <= interval_dn;
                    end else begin
                        catch_cnt <= catch_sum;
                    end
                    if (miss_sum >= 5'(MAX_MISSES)) state <= S_GAME_OVER;
                end
            end
        end
    end
endmodule
